// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the accumulator CPU run controller, the CPU core and the board top.
package cpu_ctrl_pkg;

   localparam int unsigned PC_WIDTH_DEFAULT     = 5;
   localparam int unsigned OPCODE_WIDTH_DEFAULT = 4;
   localparam logic [3:0]  HALT_OPCODE_DEFAULT  = 4'hF;

   typedef enum logic [1:0] {
      StHalt  = 2'd0,
      StRun   = 2'd1,
      StStep  = 2'd2,
      StBreak = 2'd3
   } run_state_e;

   // Board output mux codes
   localparam logic [1:0] DISPLAY_REGISTER1   = 2'd0;
   localparam logic [1:0] DISPLAY_PC          = 2'd1;
   localparam logic [1:0] DISPLAY_ACCUMULATOR = 2'd2;
   localparam logic [1:0] DISPLAY_OPCODE      = 2'd3;

   function automatic logic [1:0] next_display(input logic [1:0] sel);
      return sel + 2'd1;
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Front-panel switch conditioner: two-flop synchronizer, debounce counter and a
// one-cycle pulse on each accepted rising edge.
module switch_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   localparam int unsigned CountWidth = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CountWidth-1:0] CountLast = CountWidth'(DEBOUNCE_CYCLES - 1);

   logic                  sync_meta_q;
   logic                  sync_out_q;
   logic                  stable_q;
   logic                  stable_d;
   logic                  stable_prev_q;
   logic [CountWidth-1:0] count_q;
   logic [CountWidth-1:0] count_d;

   // Any sample equal to the accepted level restarts the qualification window.
   always_comb begin
      stable_d = stable_q;
      count_d  = count_q;
      if (sync_out_q == stable_q) begin
         count_d = '0;
      end else if (count_q == CountLast) begin
         stable_d = sync_out_q;
         count_d  = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta_q   <= 1'b0;
         sync_out_q    <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         count_q       <= '0;
      end else begin
         sync_meta_q   <= raw;
         sync_out_q    <= sync_meta_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         count_q       <= count_d;
      end
   end

   assign rise = stable_q & ~stable_prev_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer for the accumulator CPU, plus the board display select
// (manual choice or auto-scan).
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned              PC_WIDTH        = PC_WIDTH_DEFAULT,
   parameter int unsigned              OPCODE_WIDTH    = OPCODE_WIDTH_DEFAULT,
   parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE     = HALT_OPCODE_DEFAULT,
   parameter int unsigned              DEBOUNCE_CYCLES = 16,
   parameter int unsigned              SCAN_CYCLES     = 1024
) (
   input  logic                    clock,
   input  logic                    isReset,
   input  logic                    switch,
   input  logic                    runRequest,
   input  logic                    breakEnable,
   input  logic [PC_WIDTH-1:0]     breakPc,
   input  logic [PC_WIDTH-1:0]     pc,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   input  logic                    scanEnable,
   input  logic [1:0]              manualSelect,
   output logic                    cpuEnable,
   output logic [1:0]              state,
   output logic                    stepDone,
   output logic [1:0]              select
);

   localparam int unsigned ScanWidth = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [ScanWidth-1:0] ScanLast = ScanWidth'(SCAN_CYCLES - 1);

   logic                 step_pulse;
   logic                 break_hit;
   run_state_e           state_q;
   run_state_e           state_d;
   logic                 step_done_q;
   logic [1:0]           select_q;
   logic [1:0]           select_d;
   logic [ScanWidth-1:0] scan_count_q;
   logic [ScanWidth-1:0] scan_count_d;

   switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_switch (
      .clock(clock),
      .reset(isReset),
      .raw  (switch),
      .rise (step_pulse)
   );

   assign break_hit = (breakEnable && (pc == breakPc)) || (opCode == HALT_OPCODE);

   // Decoded from the state flop so an asynchronous reset stops the core at once; the
   // instruction sitting at a breakpoint or HALT opcode is never executed while running.
   assign cpuEnable = (state_q == StStep) || ((state_q == StRun) && !break_hit);

   // Step pulses arriving in RUN or STEP are dropped rather than queued.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHalt: begin
            if (runRequest) begin
               state_d = StRun;
            end else if (step_pulse) begin
               state_d = StStep;
            end
         end
         StRun: begin
            if (break_hit) begin
               state_d = StBreak;
            end else if (!runRequest) begin
               state_d = StHalt;
            end
         end
         StStep: begin
            state_d = StHalt;
         end
         StBreak: begin
            if (!runRequest) begin
               state_d = StHalt;
            end else if (step_pulse) begin
               state_d = StStep;
            end
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // Scan rotates onward from whatever select currently shows.
   always_comb begin
      select_d     = select_q;
      scan_count_d = scan_count_q;
      if (!scanEnable) begin
         select_d     = manualSelect;
         scan_count_d = '0;
      end else if (scan_count_q == ScanLast) begin
         select_d     = next_display(select_q);
         scan_count_d = '0;
      end else begin
         scan_count_d = scan_count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge isReset) begin
      if (isReset) begin
         state_q      <= StHalt;
         step_done_q  <= 1'b0;
         select_q     <= DISPLAY_REGISTER1;
         scan_count_q <= '0;
      end else begin
         state_q      <= state_d;
         step_done_q  <= (state_q == StStep);
         select_q     <= select_d;
         scan_count_q <= scan_count_d;
      end
   end

   assign state    = state_q;
   assign stepDone = step_done_q;
   assign select   = select_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: directed scenarios then random stimulus,
// all compared every cycle against a behavioural model of the controller and a toy CPU.
module tb_cpu_run_controller;

   localparam int unsigned Deb  = 4;
   localparam int unsigned Scan = 8;

   logic       clock = 1'b0;
   logic       isReset;
   logic       sw;
   logic       runRequest;
   logic       breakEnable;
   logic [4:0] breakPc;
   logic [4:0] pc;
   logic [3:0] opCode;
   logic       scanEnable;
   logic [1:0] manualSelect;
   logic       cpuEnable;
   logic [1:0] state;
   logic       stepDone;
   logic [1:0] select;

   int checks   = 0;
   int failures = 0;

   // Model state: 0 HALT, 1 RUN, 2 STEP, 3 BREAK
   int         m_state;
   bit         m_stable;
   bit         m_pulse;
   bit         m_step_done;
   int         m_sel;
   int         m_scan_age;
   bit         sw_hist[$];
   logic [3:0] prog[32];
   int         en_seen;
   int         step_seen;

   cpu_run_controller #(
      .PC_WIDTH       (5),
      .OPCODE_WIDTH   (4),
      .HALT_OPCODE    (4'hF),
      .DEBOUNCE_CYCLES(Deb),
      .SCAN_CYCLES    (Scan)
   ) dut (
      .clock       (clock),
      .isReset     (isReset),
      .switch      (sw),
      .runRequest  (runRequest),
      .breakEnable (breakEnable),
      .breakPc     (breakPc),
      .pc          (pc),
      .opCode      (opCode),
      .scanEnable  (scanEnable),
      .manualSelect(manualSelect),
      .cpuEnable   (cpuEnable),
      .state       (state),
      .stepDone    (stepDone),
      .select      (select)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state     = 0;
      m_stable    = 1'b0;
      m_pulse     = 1'b0;
      m_step_done = 1'b0;
      m_sel       = 0;
      m_scan_age  = 0;
      sw_hist.delete();
      for (int i = 0; i < int'(Deb) + 2; i++) sw_hist.push_back(1'b0);
   endfunction

   function automatic bit exp_break();
      return (breakEnable && (pc == breakPc)) || (opCode == 4'hF);
   endfunction

   function automatic bit exp_enable();
      return (m_state == 2) || ((m_state == 1) && !exp_break());
   endfunction

   task automatic set_pc(input logic [4:0] v);
      pc     = v;
      opCode = prog[v];
   endtask

   // One clock: check outputs at the negedge, advance the model across the posedge.
   task automatic cycle();
      int n;
      bit en;
      bit brk;
      bit flip;
      int sel_n;
      int age_n;
      @(negedge clock);
      en  = exp_enable();
      brk = exp_break();
      check("state", int'(state), m_state);
      check("cpu_enable", int'(cpuEnable), int'(en));
      check("step_done", int'(stepDone), int'(m_step_done));
      check("select", int'(select), m_sel);
      en_seen   += int'(cpuEnable);
      step_seen += int'(state == 2'd2);
      n = m_state;
      case (m_state)
         0: n = runRequest ? 1 : (m_pulse ? 2 : 0);
         1: n = brk ? 3 : (!runRequest ? 0 : 1);
         2: n = 0;
         default: n = !runRequest ? 0 : (m_pulse ? 2 : 3);
      endcase
      // Accepted level flips once the synchronized switch has disagreed for Deb edges
      sw_hist.push_front(sw);
      void'(sw_hist.pop_back());
      flip = 1'b1;
      for (int i = 2; i <= int'(Deb) + 1; i++) if (sw_hist[i] == m_stable) flip = 1'b0;
      if (!scanEnable) begin
         sel_n = int'(manualSelect);
         age_n = 0;
      end else begin
         age_n = m_scan_age + 1;
         sel_n = m_sel;
         if (age_n == int'(Scan)) begin
            age_n = 0;
            sel_n = (m_sel + 1) % 4;
         end
      end
      @(posedge clock);
      #1;
      m_step_done = (m_state == 2);
      m_state     = n;
      m_pulse     = flip && !m_stable;
      if (flip) m_stable = !m_stable;
      m_sel       = sel_n;
      m_scan_age  = age_n;
      if (en) set_pc(pc + 5'd1);
   endtask

   initial begin
      int hold;
      for (int i = 0; i < 32; i++) prog[i] = 4'h0;
      isReset      = 1'b1;
      sw           = 1'b0;
      runRequest   = 1'b0;
      breakEnable  = 1'b0;
      breakPc      = 5'd0;
      scanEnable   = 1'b0;
      manualSelect = 2'd0;
      set_pc(5'd0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", int'(state), 0);
      check("reset_cpu_enable", int'(cpuEnable), 0);
      check("reset_step_done", int'(stepDone), 0);
      check("reset_select", int'(select), 0);
      isReset = 1'b0;

      // 1: bouncy press yields exactly one step
      en_seen   = 0;
      step_seen = 0;
      repeat (3) begin
         sw = 1'b1;
         repeat (2) cycle();
         sw = 1'b0;
         repeat (2) cycle();
      end
      sw = 1'b1;
      repeat (Deb + 8) cycle();
      check("t1_enable_count", en_seen, 1);
      check("t1_step_count", step_seen, 1);
      check("t1_pc", int'(pc), 1);
      check("t1_state_halt", int'(state), 0);
      sw = 1'b0;
      repeat (Deb + 4) cycle();

      // 2: run to a PC breakpoint
      set_pc(5'd0);
      breakEnable = 1'b1;
      breakPc     = 5'd6;
      runRequest  = 1'b1;
      en_seen     = 0;
      repeat (12) cycle();
      check("t2_pc", int'(pc), 6);
      check("t2_state_break", int'(state), 3);
      check("t2_enable_count", en_seen, 6);

      // 3: step over the breakpoint, then resume running
      step_seen = 0;
      sw = 1'b1;
      repeat (Deb + 10) cycle();
      check("t3_step_count", step_seen, 1);
      check("t3_state_run", int'(state), 1);
      check("t3_pc_past_break", int'(pc >= 5'd8), 1);
      sw = 1'b0;
      repeat (Deb + 4) cycle();

      // 4: HALT opcode and runRequest drop in the same cycle
      runRequest  = 1'b0;
      repeat (2) cycle();
      breakEnable = 1'b0;
      prog[3]     = 4'hF;
      set_pc(5'd0);
      runRequest  = 1'b1;
      for (int i = 0; i < 20 && pc != 5'd3; i++) cycle();
      check("t4_reach_pc3", int'(pc), 3);
      runRequest = 1'b0;
      cycle();
      check("t4_state_break", int'(state), 3);
      check("t4_pc_held", int'(pc), 3);
      cycle();
      check("t4_state_halt", int'(state), 0);
      prog[3] = 4'h0;
      set_pc(pc);

      // 5: display auto-scan from select=2, then back to manual
      manualSelect = 2'd2;
      cycle();
      check("t5_manual2", int'(select), 2);
      scanEnable = 1'b1;
      repeat (Scan) cycle();
      check("t5_scan3", int'(select), 3);
      repeat (Scan) cycle();
      check("t5_scan0", int'(select), 0);
      repeat (Scan) cycle();
      check("t5_scan1", int'(select), 1);
      scanEnable   = 1'b0;
      manualSelect = 2'd1;
      cycle();
      check("t5_manual1", int'(select), 1);

      // 6: asynchronous reset between edges while running
      set_pc(5'd10);
      runRequest = 1'b1;
      repeat (3) cycle();
      check("t6_running", int'(state), 1);
      #2;
      isReset = 1'b1;
      #1;
      check("t6_async_state", int'(state), 0);
      check("t6_async_cpu_enable", int'(cpuEnable), 0);
      check("t6_async_select", int'(select), 0);
      check("t6_async_step_done", int'(stepDone), 0);
      model_reset();
      runRequest = 1'b0;
      @(posedge clock);
      #1;
      isReset = 1'b0;
      repeat (6) cycle();
      check("t6_stays_halt", int'(state), 0);

      // Random phase
      for (int i = 0; i < 32; i++) prog[i] = ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      set_pc(pc);
      hold = 0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 15) == 0) runRequest = ~runRequest;
         if ($urandom_range(0, 31) == 0) begin
            breakEnable = ~breakEnable;
            breakPc     = 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 63) == 0) scanEnable = ~scanEnable;
         if ($urandom_range(0, 7) == 0) manualSelect = 2'($urandom_range(0, 3));
         if (hold == 0) begin
            sw   = ~sw;
            hold = $urandom_range(1, 10);
         end else begin
            hold--;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/step/breakpoint sequencer for the accumulator CPU. It drives a clock-enable into the CPU core, debounces the front-panel step switch, and stops execution on a PC breakpoint or a HALT opcode. It also owns the 2-bit display select that picks register1/pc/accumulator/opCode on the board output, either as a manual choice or as an auto-scan.

Parameters:
PC_WIDTH, 5, width of CPU program counter
OPCODE_WIDTH, 4, width of CPU opcode
HALT_OPCODE, 4'hF, opcode that forces a stop
DEBOUNCE_CYCLES, 16, stable cycles required before a switch change is accepted (>=2)
SCAN_CYCLES, 1024, cycles per display slot in auto-scan (>=2)

Ports:
clock  in  1  system clock
isReset  in  1  reset, asynchronous, active-high
switch  in  1  raw, bouncy, asynchronous step button
runRequest  in  1  level; 1 = run continuously, 0 = halt
breakEnable  in  1  enables PC breakpoint compare
breakPc  in  PC_WIDTH  breakpoint address
pc  in  PC_WIDTH  current CPU program counter
opCode  in  OPCODE_WIDTH  current CPU opcode
scanEnable  in  1  1 = auto-rotate display select
manualSelect  in  2  display select used when scanEnable=0
cpuEnable  out  1  CPU clock-enable; instruction executes on cycles where high
state  out  2  FSM state: 0 HALT, 1 RUN, 2 STEP, 3 BREAK
stepDone  out  1  one-cycle pulse after a single step completes
select  out  2  display mux select

Behaviour:
- Reset: one clock, isReset asynchronous and active-high. All flops clear: state=HALT, cpuEnable=0, stepDone=0, select=0, sync/debounce/scan counters=0, debounced level=0. Reset mid-run stops the CPU immediately, because cpuEnable decodes from the state flop.
- Switch path:
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while syncd != stable; clears when they are equal.
  - When counter = DEBOUNCE_CYCLES-1 and syncd still differs: stable <= syncd, counter clears.
  - stepPulse = one cycle on rising edge of stable.
  - Latency from clean switch edge to stepPulse: 2 + DEBOUNCE_CYCLES cycles.
- breakHit (combinational) = (breakEnable & pc==breakPc) | (opCode==HALT_OPCODE).
- cpuEnable (combinational from registered state) = (state==STEP) | (state==RUN & ~breakHit).
  - The instruction at a breakpoint or HALT opcode is NOT executed in RUN.
- FSM transitions, evaluated each clock:
  - HALT: runRequest -> RUN; else stepPulse -> STEP; else stay.
  - RUN, priority order:
    1. breakHit -> BREAK
    2. ~runRequest -> HALT
    3. otherwise stay
    - If breakHit and ~runRequest occur in the same cycle, go to BREAK.
  - STEP: lasts exactly one cycle, so exactly one enabled cycle. breakHit is ignored, which allows stepping over a breakpoint. Always -> HALT.
  - BREAK: ~runRequest -> HALT; else stepPulse -> STEP; else stay.
    - Stepping from BREAK with runRequest held resumes RUN via STEP -> HALT -> RUN.
    - A HALT opcode re-breaks on its next fetch.
  - stepPulse in RUN or STEP is discarded; steps are not queued.
- stepDone: registered, equals 1 in the cycle after state==STEP, for exactly one cycle.
- Display select:
  - scanEnable=0: select <= manualSelect each clock (1-cycle latency); scan counter held at 0.
  - scanEnable=1: counter counts 0..SCAN_CYCLES-1 and wraps. On wrap, select <= select+1 mod 4 (3 -> 0).
  - Enabling the scan starts from the current select value.
- Width rules:
  - pc compare is full PC_WIDTH equality.
  - Counter widths are $clog2(DEBOUNCE_CYCLES) and $clog2(SCAN_CYCLES); no overflow beyond the terminal count.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum (HALT/RUN/STEP/BREAK, 2 bits)
  - PC_WIDTH, OPCODE_WIDTH, HALT_OPCODE defaults, shared with the CPU and board top
  - DISPLAY_* select codes (0 register1, 1 pc, 2 accumulator, 3 opCode)
- One sub-module: switch_debouncer (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES and reused for future panel buttons.

Test Plan (sim with DEBOUNCE_CYCLES=4, SCAN_CYCLES=8):
1. Reset, then switch 0->1 with 3 bounces of 2 cycles each, then held -> exactly one stepPulse and one STEP state; cpuEnable high exactly 1 cycle; stepDone high the next cycle; state returns to 0.
2. runRequest=1, breakEnable=1, breakPc=5'd6, model pc increments on cpuEnable from 0 -> cpuEnable high for pc 0..5, low at pc=6; state=3; pc stays 6.
3. From test 2, press switch -> one STEP (pc 6->7), then HALT, then RUN next cycle; running continues to pc 8+.
4. RUN with opCode=4'hF at pc=3 and runRequest dropping in the same cycle -> state=BREAK, cpuEnable=0 that cycle; then runRequest=0 -> HALT.
5. scanEnable=1 from select=2 -> select sequence 2,3,0,1 with each value held 8 cycles; set scanEnable=0, manualSelect=1 -> select=1 one cycle later.
6. Assert isReset asynchronously mid-RUN, between clock edges -> cpuEnable=0 and state=0 before the next edge; select=0, stepDone=0; after release, stays HALT until runRequest or a step.
